// File: rtl/jump_unit.sv
// jump_unit: branch-resolution unit for the ALU stage.
// Resolves the next PC for BRANCH (eight compare conditions), CALL/RET
// (through an internal circular return-address stack) and NOP, behind a
// valid/ready handshake on both sides. Results come from a registered
// output stage one cycle after accept.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous reset, asserted HIGH (legacy name)
//   i_valid/o_ready request handshake (o_ready = !o_valid | i_ready)
//   i_op            00 BRANCH, 01 CALL, 10 RET, 11 NOP
//   i_cond          BRANCH condition (EQ,NE,LT,GE,LTU,GEU,ALWAYS,NEVER)
//   i_operand0/1    compare operands
//   i_direct_addr   branch/call target
//   i_program_addr  next sequential PC, also the CALL return address
//   o_valid/i_ready result handshake
//   o_addr          resolved next PC
//   o_taken         redirect taken
//   o_ras_err       result caused RAS overflow or underflow
module jump_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_op,
    input  logic [2:0]            i_cond,
    input  logic [DATA_WIDTH-1:0] i_operand0,
    input  logic [DATA_WIDTH-1:0] i_operand1,
    input  logic [DATA_WIDTH-1:0] i_direct_addr,
    input  logic [DATA_WIDTH-1:0] i_program_addr,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_addr,
    output logic                  o_taken,
    output logic                  o_ras_err
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_RET    = 2'b10;

    logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]         sp_q, sp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  taken_q, taken_d;
    logic                  err_q, err_d;
    logic                  push_s;
    logic                  accept_s;

    function automatic logic cond_eval(input logic [2:0]            c,
                                       input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
        logic r;
        case (c)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b010:  r = ($signed(a) <  $signed(b));
            3'b011:  r = ($signed(a) >= $signed(b));
            3'b100:  r = (a <  b);
            3'b101:  r = (a >= b);
            3'b110:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign o_ready  = !valid_q | i_ready;
    assign accept_s = i_valid & o_ready;

    // Next result and next RAS pointer/count for the request on the inputs.
    always_comb begin
        addr_d  = i_program_addr;
        taken_d = 1'b0;
        err_d   = 1'b0;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        push_s  = 1'b0;
        case (i_op)
            OP_BRANCH: begin
                if (cond_eval(i_cond, i_operand0, i_operand1)) begin
                    addr_d  = i_direct_addr;
                    taken_d = 1'b1;
                end else begin
                    addr_d  = i_program_addr;
                    taken_d = 1'b0;
                end
            end
            OP_CALL: begin
                addr_d  = i_direct_addr;
                taken_d = 1'b1;
                push_s  = 1'b1;
                sp_d    = sp_q + PW'(1);
                // A full stack overwrites its oldest entry; count saturates.
                if (cnt_q == CNT_FULL) begin
                    err_d = 1'b1;
                    cnt_d = cnt_q;
                end else begin
                    err_d = 1'b0;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OP_RET: begin
                if (cnt_q != CNT_ZERO) begin
                    addr_d  = ras_q[sp_q];
                    taken_d = 1'b1;
                    sp_d    = sp_q - PW'(1);
                    cnt_d   = cnt_q - CW'(1);
                end else begin
                    // Underflow: fall through to NPC, stack untouched.
                    addr_d  = i_program_addr;
                    taken_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                addr_d  = i_program_addr;
                taken_d = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // Output register, valid flag and RAS pointer/count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= {DATA_WIDTH{1'b0}};
            taken_q <= 1'b0;
            err_q   <= 1'b0;
            sp_q    <= {PW{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else if (accept_s) begin
            valid_q <= 1'b1;
            addr_q  <= addr_d;
            taken_q <= taken_d;
            err_q   <= err_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_q;
        end
    end

    // RAS storage: push writes the slot above the current top.
    always_ff @(posedge clk) begin
        if (!rst_n && accept_s && push_s) begin
            ras_q[sp_d] <= i_program_addr;
        end
    end

    assign o_valid   = valid_q;
    assign o_addr    = addr_q;
    assign o_taken   = taken_q;
    assign o_ras_err = err_q;

endmodule

// File: tb/tb_jump_unit.sv
// Self-checking bench for jump_unit: a behavioural model pushes the
// expected result into a scoreboard on every accept; a monitor pops and
// compares whenever the DUT hands a result over.
module tb_jump_unit;

    typedef struct packed {
        logic [15:0] addr;
        logic        taken;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [2:0]  i_cond;
    logic [15:0] i_operand0, i_operand1, i_direct_addr, i_program_addr;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_addr;
    logic        o_taken;
    logic        o_ras_err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    exp_t        sb[$];
    logic [15:0] m_ras [4];
    int          m_sp  = 0;
    int          m_cnt = 0;

    jump_unit #(.DATA_WIDTH(16), .RAS_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_op           (i_op),
        .i_cond         (i_cond),
        .i_operand0     (i_operand0),
        .i_operand1     (i_operand1),
        .i_direct_addr  (i_direct_addr),
        .i_program_addr (i_program_addr),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_addr         (o_addr),
        .o_taken        (o_taken),
        .o_ras_err      (o_ras_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic model_cond(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        case (c)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) < $signed(b);
            3'd3:    return $signed(a) >= $signed(b);
            3'd4:    return a < b;
            3'd5:    return a >= b;
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_accept(input logic [1:0] op, input logic [2:0] c, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] d, input logic [15:0] npc);
        exp_t e;
        e.addr  = npc;
        e.taken = 1'b0;
        e.err   = 1'b0;
        case (op)
            2'b00: if (model_cond(c, a, b)) begin e.addr = d; e.taken = 1'b1; end
            2'b01: begin
                e.addr  = d;
                e.taken = 1'b1;
                if (m_cnt == 4) e.err = 1'b1;
                else            m_cnt = m_cnt + 1;
                m_sp = (m_sp + 1) % 4;
                m_ras[m_sp] = npc;
            end
            2'b10: begin
                if (m_cnt > 0) begin
                    e.addr  = m_ras[m_sp];
                    e.taken = 1'b1;
                    m_sp    = (m_sp + 3) % 4;
                    m_cnt   = m_cnt - 1;
                end else begin
                    e.err = 1'b1;
                end
            end
            default: ;
        endcase
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [1:0] op, input logic [2:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] d, input logic [15:0] npc);
        bit ok = 1'b0;
        i_valid = 1'b1; i_op = op; i_cond = c;
        i_operand0 = a; i_operand1 = b; i_direct_addr = d; i_program_addr = npc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_ready) begin ok = 1'b1; break; end
        end
        if (ok) model_accept(op, c, a, b, d, npc);
        else    check_val("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_op = 2'b11;
        if (ok) check_val("latency_valid", {31'd0, o_valid}, 32'd1);
    endtask

    // Scoreboard monitor: a result is consumed on the edge after a
    // low-phase with o_valid & i_ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("addr",  {16'd0, o_addr},     {16'd0, e.addr});
                check_val("taken", {31'd0, o_taken},   {31'd0, e.taken});
                check_val("ras_err", {31'd0, o_ras_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        int t0;
        rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_op = 2'b11; i_cond = 3'd0;
        i_operand0 = 16'd0; i_operand1 = 16'd0; i_direct_addr = 16'd0; i_program_addr = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", {31'd0, o_valid}, 32'd0);
        check_val("rst_addr",  {16'd0, o_addr},  32'd0);
        check_val("rst_taken", {31'd0, o_taken}, 32'd0);
        check_val("rst_err",   {31'd0, o_ras_err}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // Branch conditions: 0xFFFF vs 0x0001.
        send(2'b00, 3'd2, 16'hFFFF, 16'h0001, 16'h0100, 16'h0042); // LT  -> taken
        send(2'b00, 3'd5, 16'hFFFF, 16'h0001, 16'h0100, 16'h0042); // GEU -> taken
        send(2'b00, 3'd4, 16'hFFFF, 16'h0001, 16'h0100, 16'h0042); // LTU -> not
        send(2'b00, 3'd3, 16'hFFFF, 16'h0001, 16'h0100, 16'h0042); // GE  -> not
        send(2'b00, 3'd0, 16'h1234, 16'h1234, 16'h0100, 16'h0042); // EQ  -> taken
        send(2'b00, 3'd1, 16'h1234, 16'h1234, 16'h0100, 16'h0042); // NE  -> not
        send(2'b00, 3'd6, 16'h0000, 16'h0001, 16'h0200, 16'h0042); // ALWAYS
        send(2'b00, 3'd7, 16'h0000, 16'h0000, 16'h0200, 16'h0042); // NEVER
        send(2'b11, 3'd6, 16'h0000, 16'h0000, 16'h0300, 16'h0044); // NOP

        // CALL/RET nesting.
        send(2'b01, 3'd0, 16'h0, 16'h0, 16'h0500, 16'h0010);
        send(2'b01, 3'd0, 16'h0, 16'h0, 16'h0600, 16'h0020);
        send(2'b10, 3'd0, 16'h0, 16'h0, 16'h0000, 16'h0601);
        send(2'b10, 3'd0, 16'h0, 16'h0, 16'h0000, 16'h0501);

        // Overflow: 5 CALLs, then 5 RETs (last one underflows).
        for (int k = 1; k <= 5; k++)
            send(2'b01, 3'd0, 16'h0, 16'h0, 16'h0700, 16'(k));
        for (int k = 0; k < 5; k++)
            send(2'b10, 3'd0, 16'h0, 16'h0, 16'h0000, 16'h0900 + 16'(k));

        // Backpressure: result A held for 3 cycles while B waits.
        repeat (2) @(posedge clk);
        #1;
        i_ready = 1'b0;
        send(2'b01, 3'd0, 16'h0, 16'h0, 16'h0A00, 16'h0A01);
        fork
            send(2'b01, 3'd0, 16'h0, 16'h0, 16'h0B00, 16'h0B01);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_val("bp_ready", {31'd0, o_ready}, 32'd0);
                    check_val("bp_hold",  {16'd0, o_addr},  32'h0A00);
                end
                @(posedge clk); #1;
                i_ready = 1'b1;
            end
        join
        send(2'b10, 3'd0, 16'h0, 16'h0, 16'h0000, 16'h0C00);
        send(2'b10, 3'd0, 16'h0, 16'h0, 16'h0000, 16'h0C01);

        // Back-to-back mixed requests, one accept per cycle.
        t0 = cyc;
        for (int k = 0; k < 8; k++)
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 16'($urandom_range(0, 3)) - 16'd1, 16'($urandom_range(0, 3)) - 16'd1,
                 16'h1000 + 16'(k), 16'h2000 + 16'(k));
        check_val("b2b_cycles", 32'(cyc - t0), 32'd8);

        // Reset mid-stream with a result pending.
        repeat (2) @(posedge clk);
        #1;
        send(2'b01, 3'd0, 16'h0, 16'h0, 16'h3000, 16'h3001);
        send(2'b01, 3'd0, 16'h0, 16'h0, 16'h3100, 16'h3101);
        i_ready = 1'b0;
        rst_n   = 1'b1;
        sb.delete();
        m_sp = 0; m_cnt = 0;
        @(posedge clk); #1;
        rst_n   = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check_val("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        @(posedge clk); #1;
        send(2'b10, 3'd0, 16'h0, 16'h0, 16'h0000, 16'h4000);

        repeat (4) @(posedge clk);
        #1;
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jump_unit.md
# jump_unit

Parametrised branch-resolution unit for the bb_core ALU stage, successor to the single-compare jump-address mux. It supports eight compare conditions, CALL/RET through an internal return-address stack (RAS), and a valid/ready handshake on both sides. The selected next-PC is delivered from a registered output stage. It sits between operand read-out and the fetch-address mux.

## Interface

Parameters:
- DATA_WIDTH, 16: width of operands and addresses.
- RAS_DEPTH, 4: number of return-address entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset. The name keeps the codebase port name; the signal is asserted high.
- i_valid  input  1  request valid.
- o_ready  output  1  unit can accept a request; equals !o_valid | i_ready.
- i_op  input  2  00 BRANCH, 01 CALL, 10 RET, 11 NOP.
- i_cond  input  3  000 EQ, 001 NE, 010 LT signed, 011 GE signed, 100 LTU, 101 GEU, 110 ALWAYS, 111 NEVER. Used by BRANCH only.
- i_operand0, i_operand1  input  DATA_WIDTH  compare operands.
- i_direct_addr  input  DATA_WIDTH  branch/call target.
- i_program_addr  input  DATA_WIDTH  next sequential PC (NPC); also the return address pushed by CALL.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_addr  output  DATA_WIDTH  resolved next PC.
- o_taken  output  1  redirect taken.
- o_ras_err  output  1  result caused RAS overflow or underflow.

## Operation

- Accept occurs when i_valid & o_ready. All RAS updates and the output register load happen only on an accept edge.
- BRANCH: evaluate i_cond on operand0 vs operand1.
  - Signed compares treat both operands as two's complement DATA_WIDTH.
  - If the condition is true: o_addr = i_direct_addr, o_taken = 1. Otherwise: o_addr = i_program_addr, o_taken = 0.
  - The RAS is untouched.
- CALL: o_addr = i_direct_addr, o_taken = 1. Push i_program_addr.
  - If the RAS is full, the oldest entry is overwritten (circular), count stays at RAS_DEPTH, and o_ras_err = 1.
- RET with count > 0: o_addr = top entry, o_taken = 1, pop.
- RET with count == 0: o_addr = i_program_addr, o_taken = 0, o_ras_err = 1. Pointer and count are unchanged.
- NOP: o_addr = i_program_addr, o_taken = 0, o_ras_err = 0.
- RAS state:
  - Top pointer sp wraps modulo RAS_DEPTH.
  - count is in the range 0..RAS_DEPTH.
  - Push writes entry[sp+1] and increments sp. Pop reads entry[sp] and decrements sp.
- Output register holds o_addr, o_taken and o_ras_err stable while o_valid & !i_ready.

## Timing

- Latency: one cycle. A request accepted at edge N produces o_valid = 1 after edge N.
- Throughput: one request per cycle while i_ready = 1 (back-to-back accepts).
- Stall: while o_valid & !i_ready, o_ready = 0. No accept occurs and no RAS change occurs.
- If i_ready rises, an accept in the same cycle is permitted: the old result drains and the new one loads on that edge.
- Consecutive RET after CALL: a pop on edge N+1 sees the push made on edge N. The RAS has no read-after-write hazard.
- o_valid clears after the edge on which i_ready = 1 with no new accept.
- Reset, effective on the first edge with rst_n = 1:
  - o_valid = 0, o_addr = 0, o_taken = 0, o_ras_err = 0.
  - sp = 0, count = 0. RAS entry contents are don't-care.
  - Reset overrides any accept in the same cycle.
  - A pending result is discarded when reset is applied mid-operation.

## Test plan

- BRANCH conditions with DATA_WIDTH=16, operands 0xFFFF vs 0x0001, direct 0x0100, NPC 0x0042:
  - LT signed and GEU -> taken, o_addr 0x0100.
  - LTU and GE signed -> not taken, o_addr 0x0042.
  - EQ with 0x1234/0x1234 -> taken.
  - NEVER -> not taken.
- CALL/RET nesting: CALL at NPC 0x10, then CALL at NPC 0x20, then RET, RET -> o_addr 0x20 then 0x10, both taken, o_ras_err 0.
- RAS overflow with RAS_DEPTH=4: 5 CALLs with NPC 1..5 -> 5th result has o_ras_err = 1. Then 4 RETs return 5,4,3,2. A 5th RET -> o_ras_err = 1, o_addr = its NPC, o_taken = 0.
- Backpressure: hold i_ready = 0 for 3 cycles with i_valid = 1 -> o_ready = 0, o_addr stable, RAS count unchanged. Release -> results arrive in order, one per cycle.
- Back-to-back: 8 consecutive mixed requests with i_ready = 1 -> 8 results on 8 consecutive cycles, matching a reference model.
- Reset mid-stream: assert rst_n after 2 CALLs while o_valid = 1 -> next cycle o_valid = 0. A following RET -> underflow (o_ras_err = 1, not taken).
